// File: rtl/delay_arb_pkg.sv
// Shared types and constants for the delay timer arbiter.
package delay_arb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE, RELEASE} state_t;

  localparam int MS_W_DEFAULT = 12;
  localparam int CLKS_PER_MS  = 100000;
endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot winner pick: round-robin from (last+1), or lowest index
// when DELAY_ARB_FIXED_PRIO_EN is defined (last is then ignored).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic          o_vld
);
`ifdef DELAY_ARB_FIXED_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = ^i_last;

  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_vld && i_req[k]) begin
        o_gnt[k] = 1'b1;
        o_vld    = 1'b1;
      end
    end
  end
`else
  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_vld = 1'b0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IW'((int'(i_last) + 1 + k) % N);
      if (!o_vld && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_vld        = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/delay_arbiter.sv
// Shares one millisecond delay timer between N_REQ level requesters, one grant at a time.
// Round-robin by default; DELAY_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MS_W  = MS_W_DEFAULT
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*MS_W-1:0]   MS_IN,
  output logic [N_REQ-1:0]        ACK,
  output logic [N_REQ-1:0]        GNT,
  output logic                    BUSY,
  output logic [MS_W-1:0]         TMR_MS,
  output logic                    TMR_EN,
  input  logic                    TMR_FIN
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state;
  logic [IW-1:0]    r_own;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_gnt;
  logic             r_busy;
  logic [MS_W-1:0]  r_tmr_ms;
  logic             r_tmr_en;

  logic [IW-1:0]    w_last;
  logic [N_REQ-1:0] w_pick;
  logic             w_vld;
  logic [IW-1:0]    w_idx;

`ifdef DELAY_ARB_FIXED_PRIO_EN
  assign w_last = '0;
`else
  logic [IW-1:0] r_last;

  // Pointer starts at the top index so requester 0 wins first after reset.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      r_last <= IW'(N_REQ - 1);
    else if (r_state == IDLE && w_vld)
      r_last <= w_idx;
  end

  assign w_last = r_last;
`endif

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .i_req  (REQ),
    .i_last (w_last),
    .o_gnt  (w_pick),
    .o_vld  (w_vld)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (w_pick[i]) w_idx = IW'(i);
  end

  // Abort (owner drops REQ) is checked before TMR_FIN so a coincident finish gives no ACK.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_own    <= '0;
      r_ack    <= '0;
      r_gnt    <= '0;
      r_busy   <= 1'b0;
      r_tmr_ms <= '0;
      r_tmr_en <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_vld) begin
            r_state  <= RUN;
            r_own    <= w_idx;
            r_gnt    <= w_pick;
            r_tmr_ms <= MS_IN[w_idx*MS_W +: MS_W];
            r_tmr_en <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        RUN: begin
          if (!REQ[r_own]) begin
            r_state  <= RELEASE;
            r_gnt    <= '0;
            r_tmr_en <= 1'b0;
          end else if (TMR_FIN) begin
            r_state <= DONE;
            r_ack   <= r_gnt;
          end
        end
        DONE: begin
          if (!REQ[r_own]) begin
            r_state  <= RELEASE;
            r_ack    <= '0;
            r_gnt    <= '0;
            r_tmr_en <= 1'b0;
          end
        end
        RELEASE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ACK    = r_ack;
  assign GNT    = r_gnt;
  assign BUSY   = r_busy;
  assign TMR_MS = r_tmr_ms;
  assign TMR_EN = r_tmr_en;
endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter with a scaled-down millisecond timer model
// and a grant-order scoreboard.
module tb_delay_arbiter;
  import delay_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 12;
  localparam int unsigned TICK = CLKS_PER_MS / 10000;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic [N-1:0]   REQ = '0;
  logic [N*W-1:0] MS_IN = '0;
  logic [N-1:0]   ACK, GNT;
  logic           BUSY, TMR_EN, TMR_FIN;
  logic [W-1:0]   TMR_MS;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  delay_arbiter #(.N_REQ(N), .MS_W(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .MS_IN(MS_IN),
    .ACK(ACK), .GNT(GNT), .BUSY(BUSY),
    .TMR_MS(TMR_MS), .TMR_EN(TMR_EN), .TMR_FIN(TMR_FIN)
  );

  always #5 CLK = ~CLK;

  // Timer model: counts while enabled, done flag qualified by EN.
  int unsigned t_cnt;
  logic        t_done;
  always_ff @(posedge CLK) begin
    if (!RST_N || !TMR_EN) begin
      t_cnt  <= 0;
      t_done <= 1'b0;
    end else if (t_cnt >= TMR_MS * TICK) begin
      t_done <= 1'b1;
    end else begin
      t_cnt <= t_cnt + 1;
    end
  end
  assign TMR_FIN = t_done & TMR_EN;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_ms(input int i, input int v);
    MS_IN[i*W +: W] = W'(v);
  endtask

  task automatic wait_gnt(input string tag, output int w);
    int c = 0;
    int e;
    while (GNT == '0 && c < 400) begin
      step();
      c++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    w = (e < 0) ? 0 : e;
    chk({tag, "_gnt"}, 32'(GNT), (e < 0) ? 32'hFFFF_FFFF : (32'd1 << e));
    chk({tag, "_fin_at_gnt"}, 32'(TMR_FIN), 32'd0);
  endtask

  task automatic wait_ack(input string tag, input logic [N-1:0] expv, output int lat);
    int c = 0;
    while (ACK == '0 && c < 400) begin
      step();
      c++;
    end
    lat = c;
    chk({tag, "_ack"}, 32'(ACK), 32'(expv));
  endtask

  initial begin
    int w, lat;

    // Reset state
    step(3);
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_en", 32'(TMR_EN), 0);
    chk("rst_ms", 32'(TMR_MS), 0);
    RST_N = 1'b1;
    step(2);

    // Single request
    set_ms(2, 3);
    exp_q.push_back(2);
    REQ = 4'b0100;
    step();
    chk("single_busy", 32'(BUSY), 1);
    chk("single_en", 32'(TMR_EN), 1);
    chk("single_ms", 32'(TMR_MS), 3);
    wait_gnt("single", w);
    wait_ack("single", 4'b0100, lat);
    chk("single_lat", 32'(lat), 3 * TICK + 2);
    REQ = '0;
    step();
    chk("single_drop_ack", 32'(ACK), 0);
    chk("single_drop_en", 32'(TMR_EN), 0);
    chk("single_drop_busy", 32'(BUSY), 1);
    step();
    chk("single_idle_busy", 32'(BUSY), 0);

    // Fairness with zero delays, fresh pointer
    RST_N = 1'b0;
    step(2);
    RST_N = 1'b1;
    MS_IN = '0;
`ifdef DELAY_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) exp_q.push_back(0);
`else
    for (int i = 0; i < 5; i++) exp_q.push_back(i % N);
`endif
    REQ = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      wait_gnt("fair", w);
      wait_ack("fair", N'(1 << w), lat);
      chk("zero_lat_le5", 32'(lat <= 5), 1);
      REQ[w] = 1'b0;
      step();
      REQ[w] = 1'b1;
    end
    REQ = '0;
    step(3);

    // Abort mid-RUN, then the pending requester takes over
    set_ms(1, 5);
    set_ms(3, 1);
    exp_q.push_back(1);
    exp_q.push_back(3);
    REQ = 4'b1010;
    wait_gnt("abort", w);
    step(3);
    chk("abort_run_ack", 32'(ACK), 0);
    REQ[1] = 1'b0;
    step();
    chk("abort_rel_en", 32'(TMR_EN), 0);
    chk("abort_rel_gnt", 32'(GNT), 0);
    chk("abort_rel_ack", 32'(ACK), 0);
    chk("abort_rel_busy", 32'(BUSY), 1);
    step();
    chk("abort_idle_en", 32'(TMR_EN), 0);
    chk("abort_idle_busy", 32'(BUSY), 0);
    step();
    chk("abort_next_gnt", 32'(GNT), 32'b1000);
    wait_gnt("abort_next", w);
    wait_ack("abort_next", 4'b1000, lat);
    REQ = '0;
    step(3);

    // Reset while in DONE
    set_ms(0, 0);
    set_ms(3, 0);
    exp_q.push_back(0);
    REQ = 4'b0001;
    wait_gnt("rstdone", w);
    wait_ack("rstdone", 4'b0001, lat);
    RST_N = 1'b0;
    REQ = 4'b1001;
    step();
    chk("rstdone_gnt", 32'(GNT), 0);
    chk("rstdone_ack", 32'(ACK), 0);
    chk("rstdone_busy", 32'(BUSY), 0);
    chk("rstdone_en", 32'(TMR_EN), 0);
    chk("rstdone_ms", 32'(TMR_MS), 0);
    RST_N = 1'b1;
    exp_q.push_back(0);
    wait_gnt("post_rst", w);
    wait_ack("post_rst", 4'b0001, lat);
    REQ = '0;
    step(3);

    // TMR_FIN and REQ fall sampled on the same edge
    set_ms(2, 1);
    exp_q.push_back(2);
    REQ = 4'b0100;
    wait_gnt("simul", w);
    lat = 0;
    while (!TMR_FIN && lat < 100) begin
      step();
      lat++;
    end
    chk("simul_fin_seen", 32'(TMR_FIN), 1);
    REQ = '0;
    step();
    chk("simul_ack", 32'(ACK), 0);
    chk("simul_gnt", 32'(GNT), 0);
    chk("simul_en", 32'(TMR_EN), 0);
    step();
    chk("simul_ack2", 32'(ACK), 0);
    chk("simul_busy", 32'(BUSY), 0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
